// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master memory arbiter: FSM states, latched request
// bundle, master indices and the round-robin pick helper.
package mem_arb_pkg;

    localparam int REQ_ADDR_W = 32;
    localparam int REQ_DATA_W = 32;
    localparam int REQ_BE_W   = REQ_DATA_W / 8;

    localparam logic MASTER_IF  = 1'b0;
    localparam logic MASTER_LSU = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [REQ_BE_W-1:0]   be;
        logic [REQ_ADDR_W-1:0] addr;
        logic [REQ_DATA_W-1:0] wdata;
    } mem_req_t;

    // With both requesting, the master that did not win last time goes next.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_grant);
        if (req == 2'b11) begin
            return ~last_grant;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; remembers the last winner so ties alternate.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic       valid_o,
    output logic       grant_o
);

    logic r_last_grant;

    assign valid_o = |req_i;
    assign grant_o = rr_pick(req_i, r_last_grant);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_grant <= MASTER_LSU;
        end else if (take_i && valid_o) begin
            r_last_grant <= grant_o;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (master 0) and the
// load/store unit (master 1); every output is driven straight from a flop.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic [DATA_W-1:0]   m0_rdata_o,
    output logic                m0_ready_o,
    output logic                m0_err_o,

    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                m1_ready_o,
    output logic                m1_err_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_ready_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              r_state;
    state_e              w_state_nxt;
    mem_req_t            r_req;
    mem_req_t            w_sel_req;
    logic                r_gnt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_mem_req;
    logic [1:0]          r_ready;
    logic [1:0]          r_err;
    logic [DATA_W-1:0]   r_rdata [2];

    logic [1:0]          w_elig;
    logic                w_arb_valid;
    logic                w_arb_grant;
    logic                w_take;
    logic                w_mem_req_nxt;
    logic                w_done;
    logic                w_done_err;
    logic                w_rdata_load;
    logic                w_timeout;

    // A master is not eligible in its own ready cycle, so dropping req there
    // cannot cause a spurious second grant.
    assign w_elig    = {m1_req_i & ~r_ready[1], m0_req_i & ~r_ready[0]};
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    rr_arb2 u_rr_arb2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (w_elig),
        .take_i  (w_take),
        .valid_o (w_arb_valid),
        .grant_o (w_arb_grant)
    );

    always_comb begin
        w_sel_req.we    = w_arb_grant ? m1_we_i    : m0_we_i;
        w_sel_req.be    = w_arb_grant ? m1_be_i    : m0_be_i;
        w_sel_req.addr  = w_arb_grant ? m1_addr_i  : m0_addr_i;
        w_sel_req.wdata = w_arb_grant ? m1_wdata_i : m0_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_take        = 1'b0;
        w_mem_req_nxt = r_mem_req;
        w_done        = 1'b0;
        w_done_err    = 1'b0;
        w_rdata_load  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_arb_valid) begin
                    w_take        = 1'b1;
                    w_mem_req_nxt = 1'b1;
                    w_state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                if (mem_ready_i) begin
                    w_mem_req_nxt = 1'b0;
                    if (r_req.we) begin
                        w_done      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end else if (w_timeout) begin
                    w_mem_req_nxt = 1'b0;
                    w_done        = 1'b1;
                    w_done_err    = 1'b1;
                    w_state_nxt   = IDLE;
                end
            end
            RESP: begin
                w_done       = 1'b1;
                w_rdata_load = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_mem_req_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase
    end

    // NOTE: the read-data holding registers are reset like the rest because
    // every output must read zero out of reset; they are flops, not a RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_req     <= '0;
            r_gnt     <= MASTER_IF;
            r_cnt     <= '0;
            r_mem_req <= 1'b0;
            r_ready   <= '0;
            r_err     <= '0;
            for (int i = 0; i < 2; i++) begin
                r_rdata[i] <= '0;
            end
        end else begin
            r_mem_req <= w_mem_req_nxt;
            r_ready   <= '0;
            r_err     <= '0;
            if (w_take) begin
                r_req <= w_sel_req;
                r_gnt <= w_arb_grant;
                r_cnt <= '0;
            end else if (r_state == ISSUE) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done) begin
                r_ready[r_gnt] <= 1'b1;
                r_err[r_gnt]   <= w_done_err;
            end
            // An aborted read returns zero data; writes leave rdata untouched.
            if (w_done_err && !r_req.we) begin
                r_rdata[r_gnt] <= '0;
            end else if (w_rdata_load) begin
                r_rdata[r_gnt] <= mem_rdata_i;
            end
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_req.we;
    assign mem_be_o    = r_req.be;
    assign mem_addr_o  = r_req.addr;
    assign mem_wdata_o = r_req.wdata;

    assign m0_ready_o  = r_ready[0];
    assign m0_err_o    = r_err[0];
    assign m0_rdata_o  = r_rdata[0];
    assign m1_ready_o  = r_ready[1];
    assign m1_err_o    = r_err[1];
    assign m1_rdata_o  = r_rdata[1];

endmodule
